// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the chunked pipelined adder.
// Latency: n/a (package only).
// Backpressure: n/a.
package pipelined_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of carry-resolving stages. Guards against CHUNK=0 so the
  // configuration check in the top reports the problem instead of a
  // divide-by-zero.
  function automatic int adder_latency(input int width, input int chunk);
    return (chunk >= 1) ? (width / chunk) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational add with carry-in and carry-out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage holds the operands.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract resolving CHUNK bits per stage, carry registered between stages.
// Latency: LATENCY+1 edges from acceptance (input register plus LATENCY carry stages).
// Backpressure: global stall; every stage holds while out_valid && !out_ready.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LATENCY = adder_latency(WIDTH, CHUNK);

  if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Layer 0 is the input register (effective operands); layer k+1 holds the
  // beat after chunk k has been resolved. Full operands ride along so the
  // last layer still has the sign bits needed for overflow.
  logic             v_q [LATENCY+1];
  logic             v_d [LATENCY+1];
  logic [WIDTH-1:0] a_q [LATENCY+1];
  logic [WIDTH-1:0] a_d [LATENCY+1];
  logic [WIDTH-1:0] b_q [LATENCY+1];
  logic [WIDTH-1:0] b_d [LATENCY+1];
  logic [WIDTH-1:0] s_q [LATENCY+1];
  logic [WIDTH-1:0] s_d [LATENCY+1];
  logic             c_q [LATENCY+1];
  logic             c_d [LATENCY+1];

  logic [CHUNK-1:0] chunk_sum [LATENCY];
  logic             chunk_co  [LATENCY];

  logic sub_mode;
  logic advance;

  assign sub_mode = (sub == MODE_SUB);
  assign advance  = out_ready || !v_q[LATENCY];
  assign in_ready = !rst && advance;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    adder_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a_i (a_q[k][k*CHUNK +: CHUNK]),
      .b_i (b_q[k][k*CHUNK +: CHUNK]),
      .c_i (c_q[k]),
      .s_o (chunk_sum[k]),
      .c_o (chunk_co[k])
    );
  end

  // Next-state for every layer: capture inputs, then splice each resolved chunk in.
  always_comb begin
    v_d[0] = in_valid;
    a_d[0] = a;
    b_d[0] = b ^ {WIDTH{sub_mode}};
    c_d[0] = cin ^ sub_mode;
    s_d[0] = '0;
    for (int k = 0; k < LATENCY; k++) begin
      v_d[k+1] = v_q[k];
      a_d[k+1] = a_q[k];
      b_d[k+1] = b_q[k];
      c_d[k+1] = chunk_co[k];
      s_d[k+1] = (s_q[k] & ~(WIDTH'({CHUNK{1'b1}}) << (k*CHUNK)))
               | (WIDTH'(chunk_sum[k]) << (k*CHUNK));
    end
  end

  // Stage registers: cleared by reset, all advance together or all hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LATENCY; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k <= LATENCY; k++) begin
        v_q[k] <= v_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign out_valid = v_q[LATENCY];
  assign sum       = s_q[LATENCY];
  assign cout      = c_q[LATENCY];
  // Operands share a sign but the result does not; zero after reset.
  assign ovf       = (a_q[LATENCY][WIDTH-1] == b_q[LATENCY][WIDTH-1])
                  && (s_q[LATENCY][WIDTH-1] != a_q[LATENCY][WIDTH-1]);

  // Only the sign bits of the final operand copies are consumed.
  logic unused_low_bits;
  assign unused_low_bits = ^{a_q[LATENCY][WIDTH-2:0], b_q[LATENCY][WIDTH-2:0]};

endmodule
